// File: rtl/jkff_pkg.sv
// Shared types for the JK-cell command arbiter: command opcodes ({j,k}) and FSM states.
package jkff_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset; {j,k} follows the op encoding.
module jk_cell
  import jkff_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= 1'b0;
    end else begin
      case (op_e'({j, k}))
        OP_CLEAR:  q_reg <= 1'b0;
        OP_SET:    q_reg <= 1'b1;
        OP_TOGGLE: q_reg <= ~q_reg;
        default:   q_reg <= q_reg;
      endcase
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/jkff_cmd_arbiter.sv
// Two-requester round-robin arbiter issuing one JK command at a time to a bank of N cells.
module jkff_cmd_arbiter
  import jkff_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [1:0]    op0,
  input  logic [IW-1:0] idx0,
  input  logic [1:0]    op1,
  input  logic [IW-1:0] idx1,
  output logic [1:0]    gnt,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  q
);

  state_e        state_reg, state_next;
  logic          last_reg;
  op_e           op_reg;
  logic [IW-1:0] idx_reg;
  logic [1:0]    gnt_reg;
  logic          done_reg;
  logic          grant_valid;
  logic          grant_sel;
  logic [N-1:0]  j_vec, k_vec, q_vec;

  // last_reg names the requester granted most recently; on contention the other one wins.
  always_comb begin
    state_next  = state_reg;
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req != 2'b00) begin
          grant_valid = 1'b1;
          grant_sel   = (req == 2'b11) ? ~last_reg : req[1];
          state_next  = ST_APPLY;
        end
      end
      ST_APPLY: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      last_reg  <= 1'b1;
      op_reg    <= OP_HOLD;
      idx_reg   <= '0;
      gnt_reg   <= 2'b00;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= grant_valid ? (grant_sel ? 2'b10 : 2'b01) : 2'b00;
      done_reg  <= (state_reg == ST_APPLY);
      if (grant_valid) begin
        last_reg <= grant_sel;
        op_reg   <= grant_sel ? op_e'(op1) : op_e'(op0);
        idx_reg  <= grant_sel ? idx1 : idx0;
      end
    end
  end

  // Only the addressed cell sees the command, and only while in APPLY;
  // an index beyond the bank matches no cell and therefore changes nothing.
  for (genvar gi = 0; gi < N; gi++) begin : g_cell
    logic hit;
    assign hit       = (state_reg == ST_APPLY) && (idx_reg == IW'(gi));
    assign j_vec[gi] = hit & op_reg[1];
    assign k_vec[gi] = hit & op_reg[0];

    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j_vec[gi]),
      .k   (k_vec[gi]),
      .q   (q_vec[gi])
    );
  end

  assign gnt  = gnt_reg;
  assign done = done_reg;
  assign busy = (state_reg != ST_IDLE);
  assign q    = q_vec;

endmodule

// File: tb/tb_jkff_cmd_arbiter.sv
// Randomized and directed bench for jkff_cmd_arbiter against a behavioural bank/arbiter model.
module tb_jkff_cmd_arbiter;

  localparam logic [1:0] HOLD = 2'b00, CLR = 2'b01, SET = 2'b10, TGL = 2'b11;

  logic       clk, rst;
  logic [1:0] req, op0, op1;
  logic [2:0] idx0, idx1;
  logic [1:0] gnt;
  logic       busy, done;
  logic [7:0] q;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: bank contents and who was granted last.
  logic [7:0] q_m;
  int         last_m;

  jkff_cmd_arbiter #(.N(8), .IW(3)) dut (
    .clk(clk), .rst(rst), .req(req), .op0(op0), .idx0(idx0),
    .op1(op1), .idx1(idx1), .gnt(gnt), .busy(busy), .done(done), .q(q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int winner(input logic [1:0] r);
    if (r == 2'b11) return (last_m == 0) ? 1 : 0;
    return r[1] ? 1 : 0;
  endfunction

  task automatic model_apply(input logic [1:0] op, input int idx);
    if (idx < 8) begin
      if (op == CLR) q_m[idx] = 1'b0;
      else if (op == SET) q_m[idx] = 1'b1;
      else if (op == TGL) q_m[idx] = ~q_m[idx];
    end
  endtask

  task automatic model_grant(input logic [1:0] r);
    int w;
    w = winner(r);
    last_m = w;
    if (w == 0) model_apply(op0, int'(idx0));
    else model_apply(op1, int'(idx1));
  endtask

  // Runs one complete command from IDLE, updating the model only.
  task automatic drive_cmd(input logic [1:0] r, input logic [1:0] o, input logic [2:0] i);
    req = r; op0 = o; idx0 = i; op1 = o; idx1 = i;
    model_grant(r);
    @(negedge clk); req = 2'b00;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b00; op0 = HOLD; op1 = HOLD; idx0 = 3'd0; idx1 = 3'd0;
    @(negedge clk); @(negedge clk);
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", q); end
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0; q_m = 8'h00; last_m = 1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_single_set();
    req = 2'b01; op0 = SET; idx0 = 3'd3;
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL single_gnt got=%b exp=01", gnt); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    req = 2'b00;
    @(negedge clk);
    checks++; if (q !== 8'h08 || done !== 1'b1) begin failures++; $display("FAIL single_done q=%h done=%b exp q=08 done=1", q, done); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL single_idle busy=%b done=%b exp 0 0", busy, done); end
    q_m = 8'h08; last_m = 0;
    $display("test_single_set done q=%h", q);
  endtask

  task automatic test_round_robin();
    test_reset();
    req = 2'b11; op0 = SET; idx0 = 3'd0; op1 = SET; idx1 = 3'd1;
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL rr_first_gnt got=%b exp=01", gnt); end
    @(negedge clk);
    checks++; if (q !== 8'h01 || done !== 1'b1) begin failures++; $display("FAIL rr_first_done q=%h done=%b exp 01 1", q, done); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_gap_busy got=%b exp=0", busy); end
    @(negedge clk);
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL rr_second_gnt got=%b exp=10", gnt); end
    @(negedge clk);
    checks++; if (q !== 8'h03 || done !== 1'b1) begin failures++; $display("FAIL rr_second_done q=%h done=%b exp 03 1", q, done); end
    req = 2'b00;
    @(negedge clk);
    q_m = 8'h03; last_m = 1;
    $display("test_round_robin done q=%h", q);
  endtask

  task automatic test_toggle_seq();
    logic [2:0] exp_bits;
    int n;
    drive_cmd(2'b01, SET, 3'd5);
    exp_bits = 3'b010;
    n = 0;
    req = 2'b01; op0 = TGL; idx0 = 3'd5;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if (done !== (k % 3 == 2)) begin failures++; $display("FAIL toggle_done_k%0d got=%b exp=%b", k, done, (k % 3 == 2)); end
      if (k % 3 == 2) begin
        checks++;
        if (q[5] !== exp_bits[2 - n]) begin failures++; $display("FAIL toggle_q5_%0d got=%b exp=%b", n, q[5], exp_bits[2 - n]); end
        n++;
      end
      if (k == 8) req = 2'b00;
    end
    q_m[5] = 1'b0; last_m = 0;
    $display("test_toggle_seq done q=%h", q);
  endtask

  task automatic test_hold_clear();
    for (int i = 0; i < 8; i++) drive_cmd(2'b01, SET, 3'(i));
    req = 2'b01; op0 = HOLD; idx0 = 3'd2;
    @(negedge clk); req = 2'b00;
    @(negedge clk);
    checks++; if (q !== 8'hFF || done !== 1'b1) begin failures++; $display("FAIL hold_q q=%h done=%b exp FF 1", q, done); end
    @(negedge clk);
    req = 2'b01; op0 = CLR; idx0 = 3'd2;
    @(negedge clk); req = 2'b00;
    @(negedge clk);
    checks++; if (q !== 8'hFB || done !== 1'b1) begin failures++; $display("FAIL clear_q q=%h done=%b exp FB 1", q, done); end
    @(negedge clk);
    q_m = 8'hFB; last_m = 0;
    $display("test_hold_clear done q=%h", q);
  endtask

  task automatic test_reset_abort();
    req = 2'b01; op0 = SET; idx0 = 3'd7;
    @(negedge clk);
    rst = 1'b1; req = 2'b00;
    @(negedge clk);
    checks++; if (q !== 8'h00 || done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_state q=%h done=%b busy=%b exp 00 0 0", q, done, busy); end
    rst = 1'b0; q_m = 8'h00; last_m = 1;
    req = 2'b10; op1 = SET; idx1 = 3'd2;
    @(negedge clk);
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL abort_regrant got=%b exp=10", gnt); end
    req = 2'b00;
    @(negedge clk);
    checks++; if (q !== 8'h04) begin failures++; $display("FAIL abort_after_q got=%h exp=04", q); end
    @(negedge clk);
    q_m = 8'h04; last_m = 1;
    $display("test_reset_abort done q=%h", q);
  endtask

  task automatic test_latch();
    logic [7:0] exp_q;
    req = 2'b01; op0 = SET; idx0 = 3'd1;
    exp_q = q_m; exp_q[1] = 1'b1;
    @(negedge clk);
    op0 = CLR; idx0 = 3'd6; req = 2'b00;
    @(negedge clk);
    checks++; if (q !== exp_q) begin failures++; $display("FAIL latch_q got=%h exp=%h", q, exp_q); end
    @(negedge clk);
    q_m = exp_q; last_m = 0;
    $display("test_latch done q=%h", q);
  endtask

  task automatic test_random();
    logic [1:0] r;
    logic [1:0] exp_gnt;
    for (int it = 0; it < 40; it++) begin
      r = 2'($urandom_range(1, 3));
      op0 = 2'($urandom); idx0 = 3'($urandom);
      op1 = 2'($urandom); idx1 = 3'($urandom);
      req = r;
      exp_gnt = (winner(r) == 1) ? 2'b10 : 2'b01;
      model_grant(r);
      @(negedge clk);
      checks++; if (gnt !== exp_gnt) begin failures++; $display("FAIL rand_gnt_%0d got=%b exp=%b", it, gnt, exp_gnt); end
      req = 2'b00; op0 = 2'($urandom); idx0 = 3'($urandom); op1 = 2'($urandom); idx1 = 3'($urandom);
      @(negedge clk);
      checks++; if (q !== q_m || done !== 1'b1) begin failures++; $display("FAIL rand_q_%0d q=%h done=%b exp %h 1", it, q, done, q_m); end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || gnt !== 2'b00) begin failures++; $display("FAIL rand_idle_%0d busy=%b gnt=%b exp 0 00", it, busy, gnt); end
      $display("rand %0d req=%b gnt=%b q=%h", it, r, exp_gnt, q);
    end
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_round_robin();
    test_toggle_seq();
    test_hold_clear();
    test_reset_abort();
    test_latch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
